// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU and multiply/divide unit.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/alu_mdu_alu_core.sv
// Purely combinational ALU: result, equality flag and signed overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned SHW = ($clog2(WIDTH) < 5) ? $clog2(WIDTH) : 5;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sh   = shamt[SHW-1:0];
  assign sum  = a + b;
  assign diff = a - b;
  assign zero = (a == b);

  // Result mux; overflow only meaningful for ADD/SUB.
  always_comb begin
    alu_out = '0;
    ovf     = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_ADD: begin
        alu_out = sum;
        ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_out = diff;
        ovf     = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  alu_out = a & b;
      ALU_OR:   alu_out = a | b;
      ALU_XOR:  alu_out = a ^ b;
      ALU_NOR:  alu_out = ~(a | b);
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_out = b << sh;
      ALU_SRL:  alu_out = b >> sh;
      ALU_SRA:  alu_out = $signed(b) >>> sh;
      ALU_LUI:  alu_out = b << (WIDTH/2);
      default:  alu_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU plus multi-cycle multiply/divide unit owning HI/LO.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = ALU_WIDTH,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             ovf,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  input  logic             md_cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned MAXC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a       (a),
    .b       (b),
    .alu_op  (alu_op),
    .shamt   (shamt),
    .alu_out (alu_out),
    .zero    (zero),
    .ovf     (ovf)
  );

  md_state_e          state, next_state;
  md_op_e             op_code;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [CW-1:0]      count, last;
  logic               accept, done, is_div;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  assign busy   = (state == ST_RUN);
  assign is_div = (op_code == MD_DIV) || (op_code == MD_DIVU);
  assign last   = is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next state, issue acceptance and completion strobe; cancel always wins.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (md_start && !md_cancel) begin
          accept = 1'b1;
          if (md_op_e'(md_op) inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU})
            next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (md_cancel) begin
          next_state = ST_IDLE;
        end else if (count == last) begin
          next_state = ST_IDLE;
          done       = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Result datapath from latched operands. Signed division is done on
  // magnitudes so MIN / -1 naturally wraps to MIN with zero remainder.
  always_comb begin
    logic             signed_div, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b, divisor, uq, ur;
    if (op_code == MD_MULT)
      prod = {{WIDTH{op_a[WIDTH-1]}}, op_a} * {{WIDTH{op_b[WIDTH-1]}}, op_b};
    else
      prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
    signed_div = (op_code == MD_DIV);
    a_neg      = signed_div && op_a[WIDTH-1];
    b_neg      = signed_div && op_b[WIDTH-1];
    mag_a      = a_neg ? -op_a : op_a;
    mag_b      = b_neg ? -op_b : op_b;
    divisor    = (op_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
    uq         = mag_a / divisor;
    ur         = mag_a % divisor;
    quot       = (a_neg ^ b_neg) ? -uq : uq;
    rem        = a_neg ? -ur : ur;
  end

  // Operand latches, cycle counter, HI/LO and divide-by-zero pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      count    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= MD_NONE;
    end else begin
      div_zero <= 1'b0;
      if (accept) begin
        case (md_op_e'(md_op))
          MD_MTHI: hi <= a;
          MD_MTLO: lo <= a;
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            op_a    <= a;
            op_b    <= b;
            op_code <= md_op_e'(md_op);
            count   <= '0;
          end
          default: ;
        endcase
      end else if (busy && !md_cancel) begin
        if (done) begin
          if (!is_div) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (op_b == '0) begin
            div_zero <= 1'b1;
          end else begin
            hi <= rem;
            lo <= quot;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu.
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] a, b;
  logic [3:0]  alu_op;
  logic [4:0]  shamt;
  logic [31:0] alu_out;
  logic        zero, ovf;
  logic [2:0]  md_op;
  logic        md_start, md_cancel;
  logic        busy;
  logic [31:0] hi, lo;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .shamt     (shamt),
    .alu_out   (alu_out),
    .zero      (zero),
    .ovf       (ovf),
    .md_op     (md_op),
    .md_start  (md_start),
    .md_cancel (md_cancel),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input alu_op_e op, input logic [31:0] x, input logic [31:0] y,
                     input logic [4:0] s);
    alu_op = op;
    a      = x;
    b      = y;
    shamt  = s;
    #1;
  endtask

  task automatic issue(input md_op_e op, input logic [31:0] x, input logic [31:0] y);
    md_op    = op;
    a        = x;
    b        = y;
    md_start = 1'b1;
    step();
    md_start = 1'b0;
  endtask

  // Counts cycles until busy drops; also counts div_zero highs seen while busy.
  task automatic wait_idle(output int cycles, output int dz_seen);
    cycles  = 0;
    dz_seen = 0;
    while (busy && cycles < 100) begin
      if (div_zero) dz_seen++;
      step();
      cycles++;
    end
  endtask

  int cyc, dz;

  initial begin
    reset_n = 1'b0; a = '0; b = '0; alu_op = '0; shamt = '0;
    md_op = '0; md_start = 1'b0; md_cancel = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dz", div_zero, 0);

    // ALU
    alu(ALU_ADD, 32'h7FFFFFFF, 32'h1, 0);
    check("add_out", alu_out, 32'h80000000);
    check("add_ovf", ovf, 1);
    alu(ALU_SUB, 32'h0, 32'h1, 0);
    check("sub_out", alu_out, 32'hFFFFFFFF);
    check("sub_ovf", ovf, 0);
    alu(ALU_SUB, 32'h80000000, 32'h1, 0);
    check("sub_min_out", alu_out, 32'h7FFFFFFF);
    check("sub_min_ovf", ovf, 1);
    alu(ALU_AND, 32'hF0F000FF, 32'h0FF00F0F, 0);
    check("and", alu_out, 32'h00F0000F);
    check("and_ovf", ovf, 0);
    check("zero_ne", zero, 0);
    alu(ALU_OR, 32'hF0F000FF, 32'h0FF00F0F, 0);
    check("or", alu_out, 32'hFFF00FFF);
    alu(ALU_XOR, 32'hF0F000FF, 32'h0FF00F0F, 0);
    check("xor", alu_out, 32'hFF000FF0);
    alu(ALU_NOR, 32'hF0F000FF, 32'h0FF00F0F, 0);
    check("nor", alu_out, 32'h000FF000);
    alu(ALU_SLT, 32'hFFFFFFFF, 32'h1, 0);
    check("slt", alu_out, 32'h1);
    alu(ALU_SLTU, 32'hFFFFFFFF, 32'h1, 0);
    check("sltu", alu_out, 32'h0);
    alu(ALU_SLL, 32'h0, 32'h1, 31);
    check("sll", alu_out, 32'h80000000);
    alu(ALU_SRL, 32'h0, 32'h80000000, 4);
    check("srl", alu_out, 32'h08000000);
    alu(ALU_SRA, 32'h0, 32'h80000000, 4);
    check("sra", alu_out, 32'hF8000000);
    alu(ALU_LUI, 32'h0, 32'h00001234, 0);
    check("lui", alu_out, 32'h12340000);
    alu(ALU_ADD, 32'h5, 32'h5, 0);
    check("zero_eq", zero, 1);
    alu_op = 4'hF; #1;
    check("undef_op", alu_out, 32'h0);

    // Reset mid-DIV (a pending b==0 divide must not flag)
    issue(MD_MTHI, 32'h9, 32'h0);
    check("mthi9", hi, 32'h9);
    issue(MD_DIV, 32'd100, 32'h0);
    step(); step(); step();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check("rst2_busy", busy, 0);
    check("rst2_hi", hi, 0);
    check("rst2_lo", lo, 0);
    dz = 0;
    for (int i = 0; i < 12; i++) begin
      if (div_zero) dz++;
      step();
    end
    check("rst2_no_dz", dz, 0);

    // MULT / MULTU, back-to-back
    issue(MD_MULT, 32'hFFFFFFFF, 32'h2);
    check("mult_busy", busy, 1);
    wait_idle(cyc, dz);
    check("mult_cyc", cyc, 5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);
    issue(MD_MULTU, 32'hFFFFFFFF, 32'h2);
    wait_idle(cyc, dz);
    check("multu_cyc", cyc, 5);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    // DIV
    issue(MD_DIV, 32'hFFFFFFF9, 32'h2);
    wait_idle(cyc, dz);
    check("div_cyc", cyc, 10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(cyc, dz);
    check("divmin_lo", lo, 32'h80000000);
    check("divmin_hi", hi, 32'h0);
    check("divmin_dz", div_zero, 0);
    issue(MD_DIVU, 32'd100, 32'd7);
    wait_idle(cyc, dz);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // DIVU by zero
    issue(MD_MTHI, 32'h5, 32'h0);
    check("mthi5", hi, 32'h5);
    issue(MD_DIVU, 32'd77, 32'h0);
    wait_idle(cyc, dz);
    check("dz_cyc", cyc, 10);
    check("dz_early", dz, 0);
    check("dz_pulse", div_zero, 1);
    check("dz_hi", hi, 32'h5);
    check("dz_lo", lo, 32'd14);
    step();
    check("dz_drop", div_zero, 0);

    // MTLO, start-while-busy, cancel
    issue(MD_MTLO, 32'h1234, 32'h0);
    check("mtlo_lo", lo, 32'h00001234);
    check("mtlo_busy", busy, 0);
    issue(MD_MULT, 32'h3, 32'h4);
    issue(MD_MTHI, 32'hDEAD, 32'h0);
    check("ign_hi", hi, 32'h5);
    check("ign_busy", busy, 1);
    step();
    md_cancel = 1'b1;
    step();
    md_cancel = 1'b0;
    check("cancel_busy", busy, 0);
    for (int i = 0; i < 6; i++) step();
    check("cancel_hi", hi, 32'h5);
    check("cancel_lo", lo, 32'h00001234);
    md_cancel = 1'b1;
    issue(MD_MTLO, 32'hFFFF, 32'h0);
    check("cs_lo", lo, 32'h00001234);
    issue(MD_MULT, 32'h3, 32'h4);
    md_cancel = 1'b0;
    check("cs_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
